// File: rtl/imem_loader.sv
// Streams 32-bit words into instruction memory from address 0 and holds the CPU in reset until loaded.
// Define IMEM_LOADER_NOP_FILL_EN to pad the rest of memory with NOP_WORD after the program.
module imem_loader #(
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = 7
`ifdef IMEM_LOADER_NOP_FILL_EN
  ,
  parameter logic [31:0] NOP_WORD = 32'h0000_0020
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);
`ifdef IMEM_LOADER_NOP_FILL_EN
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
`ifdef IMEM_LOADER_NOP_FILL_EN
    S_FILL,
`endif
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               in_ready_d;
  logic               im_we_d;
  logic [ADDR_W-1:0]  im_addr_d;
  logic [31:0]        im_wdata_d;
  logic               cpu_hold_d;
  logic               done_d;
  logic               err_d;
  logic [CNT_W-1:0]   word_count_d;
  logic               beat;

  assign beat = in_valid && in_ready;

  // Every output is a register; this block computes all next values.
  always_comb begin
    state_d      = state_q;
    in_ready_d   = 1'b0;
    im_we_d      = 1'b0;
    im_addr_d    = im_addr;
    im_wdata_d   = im_wdata;
    cpu_hold_d   = 1'b1;
    done_d       = 1'b0;
    err_d        = err;
    word_count_d = word_count;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_LOAD;
          in_ready_d   = 1'b1;
          err_d        = 1'b0;
          word_count_d = '0;
        end
      end
      S_LOAD: begin
        in_ready_d = 1'b1;
        if (beat) begin
          im_we_d      = 1'b1;
          im_addr_d    = word_count[ADDR_W-1:0];
          im_wdata_d   = in_data;
          word_count_d = word_count + CNT_W'(1);
          // A beat that fills memory without in_last marks a truncated program.
          if (in_last || word_count == LAST_CNT) begin
            state_d    = S_FLUSH;
            in_ready_d = 1'b0;
            err_d      = !in_last;
          end
        end
      end
      S_FLUSH: begin
`ifdef IMEM_LOADER_NOP_FILL_EN
        if (word_count < DEPTH_CNT) begin
          state_d    = S_FILL;
          im_we_d    = 1'b1;
          im_addr_d  = word_count[ADDR_W-1:0];
          im_wdata_d = NOP_WORD;
        end else begin
          state_d    = S_DONE;
          cpu_hold_d = 1'b0;
          done_d     = 1'b1;
        end
`else
        state_d    = S_DONE;
        cpu_hold_d = 1'b0;
        done_d     = 1'b1;
`endif
      end
`ifdef IMEM_LOADER_NOP_FILL_EN
      S_FILL: begin
        // im_addr doubles as the fill address counter.
        if (im_addr == LAST_ADDR) begin
          state_d    = S_DONE;
          cpu_hold_d = 1'b0;
          done_d     = 1'b1;
        end else begin
          im_we_d    = 1'b1;
          im_addr_d  = im_addr + ADDR_W'(1);
          im_wdata_d = NOP_WORD;
        end
      end
`endif
      S_DONE: begin
        cpu_hold_d = 1'b0;
        done_d     = 1'b1;
        if (start) begin
          state_d      = S_LOAD;
          in_ready_d   = 1'b1;
          cpu_hold_d   = 1'b1;
          done_d       = 1'b0;
          err_d        = 1'b0;
          word_count_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      in_ready   <= 1'b0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      state_q    <= state_d;
      in_ready   <= in_ready_d;
      im_we      <= im_we_d;
      im_addr    <= im_addr_d;
      im_wdata   <= im_wdata_d;
      cpu_hold   <= cpu_hold_d;
      done       <= done_d;
      err        <= err_d;
      word_count <= word_count_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: each load's expected writes, counts and flags come from the program list.
module tb_imem_loader;

  localparam int unsigned DEPTH  = 128;
  localparam int unsigned ADDR_W = 7;
  localparam logic [31:0] NOP    = 32'h0000_0020;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_data = '0;
  logic              in_last = 1'b0;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_count;

  int total = 0;
  int bad   = 0;
  logic [31:0] prog[$];

  imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_we"},    32'(im_we),    32'd0);
    check({tag, "_addr"},  32'(im_addr),  32'd0);
    check({tag, "_wdata"}, im_wdata,      32'd0);
    check({tag, "_hold"},  32'(cpu_hold), 32'd1);
    check({tag, "_done"},  32'(done),     32'd0);
    check({tag, "_err"},   32'(err),      32'd0);
    check({tag, "_wc"},    32'(word_count), 32'd0);
  endtask

  task automatic fill_prog(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back($urandom);
  endtask

  // Feed prog; in_last on word n-1 when use_last. Model: word i lands at address i one cycle after
  // acceptance; load stops at in_last or DEPTH words; err iff stopped without in_last.
  task automatic run_load(input int n, input bit use_last, input int gap_pct,
                          input int gap_at, input int start_at);
    int idx = 0;
    int cyc = 0;
    bit active = 1'b1;
    bit gapped = 1'b0;
    bit lastbeat = 1'b0;
    bit v;
    start = 1'b1;
    step();
    start = 1'b0;
    check("ld_start_hold", 32'(cpu_hold), 32'd1);
    check("ld_start_done", 32'(done), 32'd0);
    check("ld_start_err",  32'(err), 32'd0);
    check("ld_start_wc",   32'(word_count), 32'd0);
    while (active && cyc < 2000) begin
      v = (idx < prog.size()) && ($urandom_range(99) >= 32'(gap_pct));
      if (idx == gap_at && !gapped) begin
        v = 1'b0;
        gapped = 1'b1;
      end
      in_valid = v;
      if (v) begin
        in_data = prog[idx];
        in_last = use_last && (idx == n - 1);
      end else begin
        in_data = $urandom;
        in_last = 1'($urandom_range(1));
      end
      start = (cyc == start_at);
      check("ld_ready", 32'(in_ready), 32'd1);
      step();
      start = 1'b0;
      cyc++;
      check("ld_we", 32'(im_we), 32'(v));
      if (v) begin
        check("ld_addr", 32'(im_addr), 32'(idx));
        check("ld_data", im_wdata, prog[idx]);
        lastbeat = in_last;
        idx++;
        if (lastbeat || idx == DEPTH) active = 1'b0;
      end
      check("ld_wc",   32'(word_count), 32'(idx));
      check("ld_hold", 32'(cpu_hold), 32'd1);
      check("ld_done", 32'(done), 32'd0);
    end
    check("ld_timeout", 32'(active), 32'd0);
    // Source keeps offering words after exit; none may be taken.
    in_valid = 1'b1;
    in_data  = $urandom;
    in_last  = 1'b0;
    check("fl_ready", 32'(in_ready), 32'd0);
    check("fl_err",   32'(err), 32'(!lastbeat));
`ifdef IMEM_LOADER_NOP_FILL_EN
    for (int a = idx; a < DEPTH; a++) begin
      step();
      check("fill_we",    32'(im_we), 32'd1);
      check("fill_addr",  32'(im_addr), 32'(a));
      check("fill_data",  im_wdata, NOP);
      check("fill_done",  32'(done), 32'd0);
      check("fill_ready", 32'(in_ready), 32'd0);
      check("fill_wc",    32'(word_count), 32'(idx));
    end
`endif
    step();
    check("dn_done",  32'(done), 32'd1);
    check("dn_hold",  32'(cpu_hold), 32'd0);
    check("dn_we",    32'(im_we), 32'd0);
    check("dn_ready", 32'(in_ready), 32'd0);
    check("dn_wc",    32'(word_count), 32'(idx));
    check("dn_err",   32'(err), 32'(!lastbeat));
    for (int k = 0; k < 2; k++) begin
      step();
      check("dn_idle_we",   32'(im_we), 32'd0);
      check("dn_idle_done", 32'(done), 32'd1);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b0;
    step();
    step();
    check_reset_vals("rst");
    rst = 1'b1;
    step();
    step();
    check("idle_ready", 32'(in_ready), 32'd0);
    check("idle_hold",  32'(cpu_hold), 32'd1);

    prog.delete();
    prog.push_back(32'h0022_1820);
    prog.push_back(32'h0000_0020);
    prog.push_back(32'h0060_2820);
    run_load(3, 1'b1, 0, 1, -1);

    fill_prog(DEPTH);
    run_load(DEPTH, 1'b1, 10, -1, -1);

    fill_prog(DEPTH + 4);
    run_load(DEPTH + 4, 1'b0, 15, -1, -1);

    fill_prog(10);
    run_load(10, 1'b1, 20, -1, 4);

    fill_prog(4);
    run_load(4, 1'b1, 0, -1, -1);

    for (int t = 0; t < 4; t++) begin
      n = int'($urandom_range(1, DEPTH));
      fill_prog(n);
      run_load(n, 1'b1, 30, -1, int'($urandom_range(0, 8)));
    end

    // Reset after 2 of 5 words: asynchronous abort, then idle until start.
    fill_prog(5);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = prog[i];
      in_last  = 1'b0;
      step();
      check("rs_we",   32'(im_we), 32'd1);
      check("rs_addr", 32'(im_addr), 32'(i));
    end
    in_data = prog[2];
    #2 rst = 1'b0;
    #1;
    check_reset_vals("rs_async");
    for (int k = 0; k < 2; k++) begin
      step();
      check("rs_hold_we", 32'(im_we), 32'd0);
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rs_idle_we",    32'(im_we), 32'd0);
      check("rs_idle_ready", 32'(in_ready), 32'd0);
      check("rs_idle_hold",  32'(cpu_hold), 32'd1);
      check("rs_idle_done",  32'(done), 32'd0);
      check("rs_idle_wc",    32'(word_count), 32'd0);
    end
    in_valid = 1'b0;

    run_load(5, 1'b1, 25, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
